// File: rtl/mac_result_fifo_if.sv
// Bus bundle between the MAC result FIFO and its surroundings.
// The slave modport is the FIFO's view; the master modport is the MAC/consumer side.
interface mac_result_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     m_valid;
  logic [WIDTH-1:0]         m_data;
  logic                     m_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     full;
  logic                     empty;
  logic [CNT_W-1:0]         drop_cnt;

  modport slave (
    input  in_valid, in_data, m_ready,
    output m_valid, m_data, level, full, empty, drop_cnt
  );

  modport master (
    output in_valid, in_data, m_ready,
    input  m_valid, m_data, level, full, empty, drop_cnt
  );
endinterface

// File: rtl/mac_result_fifo.sv
// First-word-fall-through FIFO that buffers MAC results. The MAC cannot be stalled,
// so a word arriving while the FIFO is full and not draining is dropped and counted.
module mac_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  mac_result_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic full_w;
  logic empty_w;
  logic pop;
  logic push;
  logic drop;

  // Status comes from the level count alone; equal pointers are ambiguous.
  assign full_w  = (level_q == LVL_W'(DEPTH));
  assign empty_w = (level_q == '0);

  assign pop  = !empty_w && bus.m_ready;
  assign push = bus.in_valid && (!full_w || pop);
  assign drop = bus.in_valid && full_w && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; level gates what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.m_valid  = !empty_w;
  assign bus.m_data   = empty_w ? '0 : mem_q[rd_ptr_q];
  assign bus.level    = level_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_mac_result_fifo.sv
// Randomised and directed bench for mac_result_fifo, checked against a queue model
// that follows the push/pop/drop rules directly.
module tb_mac_result_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  mac_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mac_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  logic [WIDTH-1:0] model_q[$];
  int               model_drops = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    logic [WIDTH-1:0] exp_data;
    int n;
    n = model_q.size();
    exp_data = (n > 0) ? model_q[0] : '0;
    checkOutput({tag, ".m_valid"}, 64'(bus.m_valid), 64'(n > 0));
    checkOutput({tag, ".m_data"}, 64'(bus.m_data), 64'(exp_data));
    checkOutput({tag, ".level"}, 64'(bus.level), 64'(n));
    checkOutput({tag, ".full"}, 64'(bus.full), 64'(n == DEPTH));
    checkOutput({tag, ".empty"}, 64'(bus.empty), 64'(n == 0));
    checkOutput({tag, ".drop_cnt"}, 64'(bus.drop_cnt), 64'(model_drops));
  endtask

  // Called at a falling edge: drive, advance the model one rising edge, then check.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
    bit do_pop;
    bit do_push;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.m_ready  = r;
    do_pop  = (model_q.size() > 0) && r;
    do_push = v && ((model_q.size() < DEPTH) || do_pop);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    else if (v && model_drops < CNT_MAX) model_drops++;
    @(negedge clk);
    checkAgainstModel(tag);
  endtask

  task automatic idleInputs();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.m_ready  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkAgainstModel("after_reset");
    checkOutput("reset_empty", 64'(bus.empty), 64'd1);

    // Asynchronous reset with two words stored.
    applyStimulus(1'b1, 32'h0000_0001, 1'b0, "rst_fill0");
    applyStimulus(1'b1, 32'h0000_0002, 1'b0, "rst_fill1");
    idleInputs();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst.m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("async_rst.m_data", 64'(bus.m_data), 64'd0);
    checkOutput("async_rst.level", 64'(bus.level), 64'd0);
    checkOutput("async_rst.empty", 64'(bus.empty), 64'd1);
    checkOutput("async_rst.full", 64'(bus.full), 64'd0);
    checkOutput("async_rst.drop_cnt", 64'(bus.drop_cnt), 64'd0);
    model_q.delete();
    model_drops = 0;
    @(negedge clk);
    rst = 1'b0;

    // Ordering.
    applyStimulus(1'b1, 32'h11, 1'b0, "ord_push");
    applyStimulus(1'b1, 32'h22, 1'b0, "ord_push");
    applyStimulus(1'b1, 32'h33, 1'b0, "ord_push");
    checkOutput("ord.level", 64'(bus.level), 64'd3);
    checkOutput("ord.head", 64'(bus.m_data), 64'h11);
    applyStimulus(1'b0, '0, 1'b1, "ord_pop");
    checkOutput("ord.second", 64'(bus.m_data), 64'h22);
    applyStimulus(1'b0, '0, 1'b1, "ord_pop");
    checkOutput("ord.third", 64'(bus.m_data), 64'h33);
    applyStimulus(1'b0, '0, 1'b1, "ord_pop");
    checkOutput("ord.empty", 64'(bus.empty), 64'd1);
    checkOutput("ord.m_valid", 64'(bus.m_valid), 64'd0);

    // Overflow drops a word and leaves contents intact.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, "ovf_fill");
    checkOutput("ovf.full", 64'(bus.full), 64'd1);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, "ovf_drop");
    checkOutput("ovf.drop_cnt", 64'(bus.drop_cnt), 64'd1);
    checkOutput("ovf.level", 64'(bus.level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf.drain", 64'(bus.m_data), 64'(32'hA0 + 32'(i)));
      applyStimulus(1'b0, '0, 1'b1, "ovf_pop");
    end
    checkOutput("ovf.drained_empty", 64'(bus.empty), 64'd1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, "fpp_fill");
    applyStimulus(1'b1, 32'h55, 1'b1, "fpp_both");
    checkOutput("fpp.level", 64'(bus.level), 64'd4);
    checkOutput("fpp.drop_cnt", 64'(bus.drop_cnt), 64'd1);
    checkOutput("fpp.head", 64'(bus.m_data), 64'hA1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, "fpp_pop");
    checkOutput("fpp.last", 64'(bus.m_data), 64'h55);
    checkOutput("fpp.last_level", 64'(bus.level), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, "fpp_pop");

    // Push into empty FIFO with ready already high.
    applyStimulus(1'b1, 32'h77, 1'b1, "emp_push");
    checkOutput("emp.m_valid", 64'(bus.m_valid), 64'd1);
    checkOutput("emp.m_data", 64'(bus.m_data), 64'h77);
    checkOutput("emp.level", 64'(bus.level), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, "emp_pop");

    // Drop counter saturation.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, 1'b0, "sat_fill");
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, $urandom, 1'b0, "sat_drop");
    checkOutput("sat.drop_cnt", 64'(bus.drop_cnt), 64'(CNT_MAX));
    applyStimulus(1'b1, $urandom, 1'b0, "sat_hold");
    checkOutput("sat.hold", 64'(bus.drop_cnt), 64'(CNT_MAX));

    // Clear and run random traffic.
    idleInputs();
    rst = 1'b1;
    model_q.delete();
    model_drops = 0;
    @(negedge clk);
    rst = 1'b0;
    checkAgainstModel("rand_reset");
    for (int i = 0; i < 1200; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
